// File: rtl/dmem_responder.sv
// Word-organised data RAM with per-byte write lanes and an address-window check.
// Define DMEM_WAIT_EN to build the wait-state FSM that back-pressures the core via stall.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        memwrite,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        addr_err,
    output logic        stall
);

    logic [31:0]       mem [2**ADDR_W];

    logic              op_go;
    logic              op_write;
    logic [3:0]        op_wen;
    logic [31:2]       op_addr;
    logic [31:0]       op_wdata;
    logic              in_win;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       merged;

    // Byte offset within the word plays no part in indexing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [3:0]  lat_wen;
    logic [31:2] lat_addr;
    logic [31:0] lat_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    lat_write <= memwrite;
                    lat_wen   <= mem_wen;
                    lat_addr  <= addr[31:2];
                    lat_wdata <= wdata;
                    cnt       <= 4'(WAIT_CYCLES - 1);
                    state     <= BUSY;
                end
                BUSY: if (cnt == '0) state <= DONE;
                      else           cnt   <= cnt - 1'b1;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign op_go    = (state == BUSY) && (cnt == '0) && !rst;
    assign op_write = lat_write;
    assign op_wen   = lat_wen;
    assign op_addr  = lat_addr;
    assign op_wdata = lat_wdata;
    assign stall    = ((state == IDLE) && req) || (state == BUSY);
`else
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;

    assign op_go    = req && !rst;
    assign op_write = memwrite;
    assign op_wen   = mem_wen;
    assign op_addr  = addr[31:2];
    assign op_wdata = wdata;
    assign stall    = 1'b0;
`endif

    assign in_win = (op_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign idx    = op_addr[ADDR_W+1:2];

    always_comb begin
        merged = mem[idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (op_wen[i]) merged[8*i +: 8] = op_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (op_go && op_write && in_win) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (op_wen[i]) mem[idx][8*i +: 8] <= op_wdata[8*i +: 8];
            end
        end
    end

    // A write response returns the post-merge word; out-of-window returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= op_go;
            addr_err <= op_go && !in_win;
            if (op_go) rdata <= !in_win ? '0 : (op_write ? merged : mem[idx]);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized accesses against an address-keyed word model.
// Follows DMEM_WAIT_EN so the same bench covers both build variants.
module tb_dmem_responder;

`ifdef DMEM_WAIT_EN
    localparam int W   = 2;
    localparam int LAT = W + 1;
`else
    localparam int W   = 0;
    localparam int LAT = 1;
`endif
    localparam logic [31:0] WIN_LO = 32'h0000_0000;
    localparam logic [31:0] WIN_HI = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        memwrite = 1'b0;
    logic [3:0]  mem_wen = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        addr_err;
    logic        stall;

    dmem_responder #(
        .ADDR_W(12),
        .BASE_ADDR(32'h0000_0000),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .memwrite(memwrite), .mem_wen(mem_wen),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .addr_err(addr_err), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [int];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every rvalid consumes one expected response.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid at cycle %0d: got 1 expected 0", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("addr_err", {31'b0, addr_err}, {31'b0, mon_e.err});
                if (mon_e.chk_data) check("rdata", rdata, mon_e.data);
            end
        end else if (!rst && addr_err !== 1'b0) begin
            check("addr_err_idle", {31'b0, addr_err}, 32'b0);
        end
`ifndef DMEM_WAIT_EN
        check("stall_zero", {31'b0, stall}, 32'b0);
`endif
    end

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the first cycle a new request may start.
    task automatic issue(input logic mw, input logic [3:0] wen, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t        e;
        logic        inwin;
        int          key;
        logic [31:0] w;
        inwin = (a >= WIN_LO) && (a < WIN_HI);
        key   = int'((a - WIN_LO) / 4);
        e.chk_data = 1'b0;
        e.data     = '0;
        e.err      = !inwin;
        if (!inwin) begin
            e.chk_data = 1'b1;
        end else if (mw) begin
            w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (ref_mem.exists(key) || wen == 4'hF) ref_mem[key] = w;
        end else if (ref_mem.exists(key)) begin
            e.chk_data = 1'b1;
            e.data     = ref_mem[key];
        end
        req = 1'b1; memwrite = mw; mem_wen = wen; addr = a; wdata = wd;
        e.cyc = cyc + LAT;
        sbq.push_back(e);
`ifdef DMEM_WAIT_EN
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            check("stall_busy", {31'b0, stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_done", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
`else
        @(posedge clk);
        #1;
`endif
        req = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       a = {$urandom_range(0, 15), 2'($urandom)};
        else if (r == 7) a = 32'h0000_3FFC | 32'($urandom_range(0, 3));
        else begin
            a = $urandom;
            if (a < WIN_HI) a = a + WIN_HI;
        end
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);
        check("reset_addr_err", {31'b0, addr_err}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;

        // Known contents for every word the random phase may touch.
        for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom);
        issue(1'b1, 4'hF, 32'h0000_3FFC, $urandom);

        // Byte lanes: expect DEAD12EF.
        issue(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        issue(1'b1, 4'b0010, 32'h40, 32'h0000_1200);
        issue(1'b0, 4'h0, 32'h40, 32'h0);

        // Back-to-back read-after-write, then an empty-lane write.
        issue(1'b1, 4'hF, 32'h8, 32'h1122_3344);
        issue(1'b0, 4'h0, 32'h8, 32'h0);
        issue(1'b1, 4'h0, 32'h8, 32'hFFFF_FFFF);
        issue(1'b0, 4'h0, 32'hB, 32'h0);

        // Window edges: first out-of-window word aliases index 0 and must not touch it.
        issue(1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D);
        issue(1'b0, 4'h0, 32'h0, 32'h0);
        issue(1'b1, 4'hF, 32'h0000_4000, 32'h5555_AAAA);
        issue(1'b0, 4'h0, 32'h0000_3FFC, 32'h0);
        issue(1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0);
        idle(3);

`ifdef DMEM_WAIT_EN
        // Reset one cycle after acceptance: the write is dropped with no response.
        req = 1'b1; memwrite = 1'b1; mem_wen = 4'hF; addr = 32'h14; wdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1 req = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b0, 4'h0, 32'h14, 32'h0);
`endif

        for (int n = 0; n < 200; n++) begin
            issue(1'($urandom), 4'($urandom), pick_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end

        idle(LAT + 6);
        check("pending_responses", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the CPU's M-stage data port: accepts the core's byte-enabled read/write requests and returns read data. It sits opposite the core's `memwriteM` / `mem_wenM` / `aluoutM_addr` / `writedataM` / `readdataM` signals. It holds a word-organised RAM with per-byte write lanes and an address-range check. Optionally it inserts wait states and back-pressures the pipeline through `stall`.

## Interface
- `ADDR_W`, 12: word-index bits; depth = 2^ADDR_W words (16 KiB at default).
- `BASE_ADDR`, 32'h0000_0000: byte base of the RAM window; must be aligned to 4·2^ADDR_W.
- `WAIT_CYCLES`, 2: wait states per access when `DMEM_WAIT_EN` is defined; legal range 1..15.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: access valid this cycle; held stable by the core while `stall`=1.
- `memwrite` in 1: 1 = write, 0 = read.
- `mem_wen` in 4: byte-lane enables; bit0 = data[7:0]. Ignored when `memwrite`=0.
- `addr` in 32: byte address; addr[1:0] are ignored for indexing.
- `wdata` in 32: write data, already lane-replicated by the core.
- `rdata` out 32: read word; registered; holds its value until the next response.
- `rvalid` out 1: one-cycle pulse per completed access, reads and writes alike.
- `addr_err` out 1: pulses together with `rvalid` when the access was out of window.
- `stall` out 1: combinational back-pressure to the core.

## Operation
- In-window test: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. RAM index = addr[ADDR_W+1:2].
- Write commit, in-window with `memwrite`=1:
  - each lane i with mem_wen[i]=1 takes wdata[8i+7:8i]; other lanes are unchanged.
  - mem_wen=4'b0000 is a no-op write, but still produces `rvalid`.
- Read, in-window with `memwrite`=0: `rdata` = the full word at the index; the core does byte extraction.
- Out-of-window access:
  - the RAM is untouched, `rdata` = 0 and `addr_err` = 1, both in the response cycle.
  - a write reads back as 0.
- FSM (`DMEM_WAIT_EN` defined): states IDLE, BUSY, DONE.
  - IDLE: if `req`=1, latch addr, wdata, mem_wen and memwrite; load cnt = WAIT_CYCLES-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: if cnt = 0, perform the RAM op using the latched values and go to DONE. Otherwise cnt decrements.
  - DONE: drive `rvalid` = 1; always return to IDLE. `req` is ignored here, because the core is still presenting the just-completed request.
  - `stall` = (IDLE & req) | BUSY.
- RAM contents are not cleared by `rst`.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `addr_err`=0, `stall`=0, state=IDLE, cnt=0.
- `rst` mid-access: return to IDLE and drop the pending op. A write whose commit edge has not yet occurred is lost. No `rvalid` is produced for it.
- With `DMEM_WAIT_EN`, for a request first presented in cycle N:
  - `stall`=1 in cycles N..N+WAIT_CYCLES.
  - write commits at the edge ending cycle N+WAIT_CYCLES.
  - `rvalid`/`rdata`/`addr_err` are valid in cycle N+WAIT_CYCLES+1, with `stall`=0 in that cycle.
- Earliest next acceptance after a response: cycle N+WAIT_CYCLES+2, i.e. a two-cycle gap between back-to-back requests.
- Read-after-write to the same word always returns the new data; the write commits before the read is sampled.

## Configuration
- `DMEM_WAIT_EN` defined: FSM and wait-state counter are built as above; `WAIT_CYCLES` is honoured.
- `DMEM_WAIT_EN` undefined: FSM and counter are removed; `WAIT_CYCLES` is ignored; `stall` is tied to 0.
  - Any cycle N with `req`=1 is an independent access; back-to-back accesses are allowed every cycle.
  - Write commits at the edge ending cycle N.
  - `rvalid`/`rdata`/`addr_err` are valid in cycle N+1.
  - Read in cycle N+1 of a word written in cycle N returns the new value in cycle N+2.

## Test plan
- Reset values: hold `rst` for 2 cycles, then release → all outputs 0. With the macro, a `req` presented 1 cycle after release is accepted normally.
- Byte lanes: write 32'hDEADBEEF with wen=4'hF to 0x40, then 32'h00001200 with wen=4'b0010 to 0x40, then read 0x40 → `rdata`=32'hDEAD12EF.
- Wait states (macro on, WAIT_CYCLES=2): read `req` in cycle 5 → `stall`=1 in cycles 5–7, `rvalid`=1 only in cycle 8, `stall`=0 in cycle 8, no second `rvalid` in cycle 9.
- Back-to-back (macro off): write 0x11223344 to 0x8 in cycle 3, read 0x8 in cycle 4 → `rvalid` in cycles 4 and 5, `rdata`=0x11223344 in cycle 5, `stall` never asserted.
- Out of window (ADDR_W=12, BASE=0): write to 0x0001_0000, then read 0x0 → `addr_err`=1 and `rdata`=0 on the first response; word 0 unchanged on the read.
- Reset mid-operation (macro on): write `req` in cycle 10, `rst` in cycle 11 → no `rvalid`; a subsequent read of that address returns the old contents.
